// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 width codes, FSM states
// and request classification helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return (addr_lo != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

  // Stores only have b/h/w; loads additionally allow the unsigned variants.
  function automatic logic is_illegal(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return is_store;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: byte enables and replicated store data
// towards the bus, shifted and extended load data back from it.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] bus_rdata_i,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  always_comb begin
    bus_be_o    = 4'b0000;
    bus_wdata_o = 32'h0;
    case (func3_i[1:0])
      2'b00: begin
        bus_be_o    = 4'b0001 << addr_lo_i;
        bus_wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        bus_be_o    = 4'b0011 << addr_lo_i;
        bus_wdata_o = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        bus_be_o    = 4'b1111;
        bus_wdata_o = wdata_i;
      end
      default: begin
        bus_be_o    = 4'b0000;
        bus_wdata_o = 32'h0;
      end
    endcase
  end

  // Bring the addressed byte/halfword down to lane 0 before extending.
  always_comb begin
    shifted     = bus_rdata_i >> {addr_lo_i, 3'b000};
    load_data_o = 32'h0;
    case (func3_i)
      F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data_o = shifted;
      F3_BU:   load_data_o = {24'h0, shifted[7:0]};
      F3_HU:   load_data_o = {16'h0, shifted[15:0]};
      default: load_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// Single-outstanding load/store unit: validates the request, drives one bus
// transaction, waits for read data with an optional timeout, then responds.
module lsu_master
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  func3,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  lsu_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  func3_q, func3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misal_q, misal_d;
  logic        err_q, err_d;

  logic [3:0]  be_w;
  logic [31:0] wdata_w;
  logic [31:0] load_w;
  logic        issue;

  lsu_lane_align u_align (
    .func3_i     (func3_q),
    .addr_lo_i   (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .bus_rdata_i (bus_rdata),
    .bus_be_o    (be_w),
    .bus_wdata_o (wdata_w),
    .load_data_o (load_w)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    func3_d = func3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    misal_d = misal_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && (MemRead || MemWrite)) begin
          we_d    = MemWrite;
          func3_d = func3;
          addr_d  = address;
          wdata_d = wdata;
          state_d = ST_RESP;
          if (MemRead && MemWrite)
            err_d = 1'b1;
          else if (is_illegal(MemWrite, func3))
            err_d = 1'b1;
          else if (is_misaligned(func3, address[1:0]))
            misal_d = 1'b1;
          else
            state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus_gnt) begin
          state_d = we_q ? ST_RESP : ST_WAIT_R;
          cnt_d   = '0;
        end
      end
      ST_WAIT_R: begin
        // Read data takes priority over a timeout landing in the same cycle.
        if (bus_rvalid) begin
          rdata_d = load_w;
          state_d = ST_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        rdata_d = 32'h0;
        misal_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      func3_q <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      misal_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      misal_q <= misal_d;
      err_q   <= err_d;
    end
  end

  // Bus-side outputs are forced to zero outside ISSUE so the idle bus is quiet.
  assign issue      = (state_q == ST_ISSUE);
  assign req_ready  = (state_q == ST_IDLE);
  assign stall      = (state_q != ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign rdata      = rdata_q;
  assign misaligned = misal_q;
  assign bus_err    = err_q;
  assign bus_req    = issue;
  assign bus_we     = issue & we_q;
  assign bus_addr   = issue ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_be     = issue ? be_w : 4'b0000;
  assign bus_wdata  = issue ? wdata_w : 32'h0;

endmodule

// File: doc/lsu_master.md
Name: lsu_master

Overview:
- Initiator-side load/store unit between the pipeline MEM stage and a byte-addressed data memory.
- Accepts one request at a time: MemRead/MemWrite, func3, address, wdata.
- Checks alignment, builds a word-aligned bus transaction with byte enables, waits for grant and read data, then returns sign- or zero-extended load data.
- Stalls the pipeline while a request is in flight.

Parameters:
- TIMEOUT, default 255, max cycles in WAIT_R before bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline request present
- req_ready  out  1  high only in IDLE
- MemRead  in  1  load request
- MemWrite  in  1  store request
- func3  in  3  RV32 width code (000 b, 001 h, 010 w, 100 bu, 101 hu)
- address  in  32  byte address
- wdata  in  32  store data, LSB-justified
- stall  out  1  high in any state other than IDLE
- resp_valid  out  1  one-cycle completion pulse
- rdata  out  32  extended load data; 0 for stores and errors
- misaligned  out  1  qualified by resp_valid
- bus_err  out  1  qualified by resp_valid; set on illegal or timed-out requests
- bus_req  out  1  bus request
- bus_we  out  1  bus write enable
- bus_addr  out  32  {address[31:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  bus grant
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  little-endian read word

Behaviour:
- Reset: state=IDLE. All outputs 0 except req_ready=1. Timeout counter = 0.
- FSM states: IDLE, ISSUE, WAIT_R, RESP.
- IDLE, req_valid with MemRead xor MemWrite: latch all request fields, then classify.
  - Illegal func3 (loads: 011/110/111; stores: any code other than 000/001/010) -> RESP with bus_err=1.
  - Misaligned (h: addr[0]!=0; w: addr[1:0]!=0) -> RESP with misaligned=1.
  - Neither error -> ISSUE.
  - No bus activity on either error path.
- IDLE, req_valid with MemRead=MemWrite=1 -> RESP with bus_err=1.
- IDLE, req_valid with neither flag set -> ignored; stays IDLE, no response.
- ISSUE:
  - bus_req=1, bus_we=MemWrite. bus_addr/bus_be/bus_wdata held stable until bus_gnt.
  - On bus_gnt: a store goes to RESP; a load goes to WAIT_R.
- Byte enables:
  - b/bu: 4'b0001<<addr[1:0]
  - h/hu: 4'b0011<<addr[1:0]
  - w: 4'b1111
- Store data: sb = {4{wdata[7:0]}}, sh = {2{wdata[15:0]}}, sw = wdata.
- WAIT_R:
  - bus_req=0.
  - On bus_rvalid: shift bus_rdata right by 8*addr[1:0], extend per func3 (b/h sign-extend, bu/hu zero-extend, w unchanged), register into rdata, go to RESP.
  - Counter increments each cycle. Reaching TIMEOUT (when nonzero) -> RESP with bus_err=1 and rdata=0.
  - bus_rvalid and timeout in the same cycle: data wins.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. rdata/misaligned/bus_err are valid only in this cycle and cleared on return to IDLE.
- bus_rvalid arriving in IDLE, ISSUE or RESP is ignored. bus_rvalid is never accepted in the cycle of bus_gnt.
- Minimum latency (accept = cycle 0):
  - error: resp_valid at cycle 1
  - store with immediate gnt: cycle 2
  - load with gnt at cycle 1 and rvalid at cycle 2: cycle 3
- Reset mid-operation: IDLE on the next edge; bus_req drops; no resp_valid for the aborted request; a late bus_rvalid is ignored.
- New requests are accepted only in IDLE. A request can be accepted in the cycle after RESP.

Decomposition:
- Package lsu_pkg:
  - func3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
  - state enum lsu_state_t
  - function is_misaligned(func3, addr[1:0])
- Sub-module lsu_lane_align (combinational):
  - produces bus_be/bus_wdata from func3, addr[1:0], wdata
  - produces extended load data from bus_rdata, func3, addr[1:0]
  - keeps the FSM file small and is unit-testable on its own.

Test Plan:
- sh addr=0x0000_0006 wdata=0xABCD_1234, gnt at cycle 1 -> bus_addr=0x4, bus_be=4'b1100, bus_wdata=0x1234_1234, bus_we=1; resp_valid at cycle 2, rdata=0.
- lb addr=0x3, bus_rdata=0x80FF_0000 -> rdata=0xFFFF_FF80; repeat as lbu -> rdata=0x0000_0080; lhu addr=0x2 -> rdata=0x0000_80FF.
- lw addr=0x2 -> no bus_req; resp_valid at cycle 1 with misaligned=1, rdata=0. func3=011 load -> bus_err=1.
- gnt withheld 3 cycles -> bus_req and bus_addr/bus_be/bus_wdata stable for all 4 ISSUE cycles; stall=1 throughout; req_ready=0.
- TIMEOUT=4, load granted, no rvalid -> resp_valid 4 cycles after entering WAIT_R with bus_err=1; a later spurious rvalid is ignored.
- rst asserted while in WAIT_R -> IDLE next cycle, req_ready=1, no resp_valid; a following sw addr=0x8 completes normally with bus_be=4'b1111.
